// File: rtl/exec_sequencer_pkg.sv
// rtl/exec_sequencer_pkg.sv - shared state, opcode/funct and alu_op encodings for the sequencer and ALU
package exec_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        ADC_WAIT,
        WB,
        HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADC   = 6'b110000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

endpackage

// File: rtl/exec_sequencer_seq_decode.sv
// rtl/exec_sequencer_seq_decode.sv - combinational opcode/funct decoder (seq_decode)
module seq_decode
    import exec_sequencer_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [1:0] alu_op,
    output logic       sel_dest,
    output logic       sel_operab,
    output logic       wr_en,
    output logic       is_adc,
    output logic       is_halt
);

    always_comb begin
        alu_op     = ALU_ADD;
        sel_dest   = 1'b0;
        sel_operab = 1'b0;
        wr_en      = 1'b0;
        is_adc     = 1'b0;
        is_halt    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                wr_en = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    default: wr_en  = 1'b0;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                wr_en      = 1'b1;
                sel_dest   = 1'b1;
                sel_operab = 1'b1;
                alu_op     = (opcode == OP_ADDI) ? ALU_ADD :
                             (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
            end
            OP_ADC:  is_adc  = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - instruction sequencer FSM, PC and restart logic
// SEQ_ADC_TIMEOUT_EN enables the ADC wait timeout counter and sticky err flag.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int PROG_DEPTH  = 16,
    parameter int ADC_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       prog_ready,
    input  logic       tick,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       adc_done,
    output logic [3:0] pc,
    output logic       ir_load,
    output logic       reg_wr,
    output logic       sel_dest,
    output logic       sel_operab,
    output logic       adc_start,
    output logic [1:0] alu_op,
    output logic       busy,
    output logic       err
);

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic       pend_q, pend_d;
    logic [1:0] alu_op_q, alu_op_d;
    logic       sel_dest_q, sel_dest_d;
    logic       sel_operab_q, sel_operab_d;
    logic       wr_en_q, wr_en_d;
    logic       adc_start_q, adc_start_d;

    logic [1:0] dec_alu_op;
    logic       dec_sel_dest, dec_sel_operab, dec_wr_en, dec_is_adc, dec_is_halt;
    logic [3:0] pc_inc;

    seq_decode u_decode (
        .opcode     (opcode),
        .funct      (funct),
        .alu_op     (dec_alu_op),
        .sel_dest   (dec_sel_dest),
        .sel_operab (dec_sel_operab),
        .wr_en      (dec_wr_en),
        .is_adc     (dec_is_adc),
        .is_halt    (dec_is_halt)
    );

`ifdef SEQ_ADC_TIMEOUT_EN
    localparam int CNT_W = $clog2(ADC_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = ADC_TIMEOUT;
    assign err = 1'b0;
`endif

    assign pc_inc = (pc_q == 4'(PROG_DEPTH - 1)) ? 4'd0 : pc_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q | (tick & (state_q != HALT));
        alu_op_d     = alu_op_q;
        sel_dest_d   = sel_dest_q;
        sel_operab_d = sel_operab_q;
        wr_en_d      = wr_en_q;
        adc_start_d  = 1'b0;
`ifdef SEQ_ADC_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
`endif
        case (state_q)
            IDLE:   if (prog_ready) state_d = FETCH;
            FETCH:  state_d = DECODE;
            DECODE: begin
                alu_op_d     = dec_alu_op;
                sel_dest_d   = dec_sel_dest;
                sel_operab_d = dec_sel_operab;
                wr_en_d      = dec_wr_en;
                if (dec_is_adc) begin
                    state_d     = ADC_WAIT;
                    adc_start_d = 1'b1;
`ifdef SEQ_ADC_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end else if (dec_is_halt) begin
                    state_d = HALT;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC:   state_d = WB;
            ADC_WAIT: begin
                if (adc_done) begin
                    state_d = WB;
`ifdef SEQ_ADC_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(ADC_TIMEOUT - 1)) begin
                    state_d = WB;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            WB: begin
                // A tick landing in this very cycle restarts just like a pending one.
                pend_d = 1'b0;
                pc_d   = (pend_q || tick) ? 4'd0 : pc_inc;
                if (!prog_ready) begin
                    pc_d    = 4'd0;
                    state_d = IDLE;
                end else begin
                    state_d = FETCH;
                end
            end
            HALT: begin
                if (tick) begin
                    pc_d    = 4'd0;
                    pend_d  = 1'b0;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= 4'd0;
            pend_q       <= 1'b0;
            alu_op_q     <= ALU_ADD;
            sel_dest_q   <= 1'b0;
            sel_operab_q <= 1'b0;
            wr_en_q      <= 1'b0;
            adc_start_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            alu_op_q     <= alu_op_d;
            sel_dest_q   <= sel_dest_d;
            sel_operab_q <= sel_operab_d;
            wr_en_q      <= wr_en_d;
            adc_start_q  <= adc_start_d;
        end
    end

    assign pc         = pc_q;
    assign ir_load    = (state_q == FETCH);
    assign reg_wr     = (state_q == WB) && wr_en_q;
    assign adc_start  = adc_start_q;
    assign alu_op     = alu_op_q;
    assign sel_dest   = sel_dest_q;
    assign sel_operab = sel_operab_q;
    assign busy       = (state_q != IDLE) && (state_q != HALT);

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - directed scoreboard bench for exec_sequencer
module tb_exec_sequencer;

    logic       clk = 1'b0;
    logic       rst, prog_ready, tick, adc_done;
    logic [5:0] opcode, funct;
    logic [3:0] pc;
    logic       ir_load, reg_wr, sel_dest, sel_operab, adc_start, busy, err;
    logic [1:0] alu_op;

    always #5 clk = ~clk;

    exec_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .prog_ready (prog_ready),
        .tick       (tick),
        .opcode     (opcode),
        .funct      (funct),
        .adc_done   (adc_done),
        .pc         (pc),
        .ir_load    (ir_load),
        .reg_wr     (reg_wr),
        .sel_dest   (sel_dest),
        .sel_operab (sel_operab),
        .adc_start  (adc_start),
        .alu_op     (alu_op),
        .busy       (busy),
        .err        (err)
    );

    logic [5:0] prog_op [16];
    logic [5:0] prog_fn [16];
    logic [5:0] ir_op = 6'd0;
    logic [5:0] ir_fn = 6'd0;

    always @(posedge clk) begin
        if (ir_load) begin
            ir_op <= prog_op[pc];
            ir_fn <= prog_fn[pc];
        end
    end

    assign opcode = ir_op;
    assign funct  = ir_fn;

    int total = 0;
    int bad   = 0;
    int wr_cnt, as_cnt, n;
    logic [3:0] exp_pc [$];
    logic [3:0] exp_wb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (ir_load && exp_pc.size() > 0) check("fetch_pc", 32'(pc), 32'(exp_pc.pop_front()));
        if (reg_wr) begin
            wr_cnt++;
            if (exp_wb.size() > 0) check("wb_ctrl", 32'({alu_op, sel_dest, sel_operab}), 32'(exp_wb.pop_front()));
        end
        if (adc_start) as_cnt++;
    endtask

    task automatic load_nops();
        for (int i = 0; i < 16; i++) begin
            prog_op[i] = 6'b000000;
            prog_fn[i] = 6'b000000;
        end
    endtask

    task automatic do_reset();
        check("sb_pc_drain", 32'(exp_pc.size()), 0);
        check("sb_wb_drain", 32'(exp_wb.size()), 0);
        rst = 1'b1; prog_ready = 1'b0; tick = 1'b0; adc_done = 1'b0;
        #1;
        check("rst_pc", 32'(pc), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_strobes", 32'({ir_load, reg_wr, adc_start}), 0);
        check("rst_alu_op", 32'(alu_op), 0);
        check("rst_err", 32'(err), 0);
        step(); step();
        rst = 1'b0;
        repeat (3) step();
        check("idle_hold", 32'({busy, pc}), 0);
        exp_pc.delete(); exp_wb.delete();
        wr_cnt = 0; as_cnt = 0;
        load_nops();
    endtask

    task automatic run_until_idle(input int maxc, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (busy && cnt < maxc);
    endtask

    initial begin
        rst = 1'b0; prog_ready = 1'b0; tick = 1'b0; adc_done = 1'b0;
        load_nops();
        #2;
        do_reset();

        // ADDI at pc 0 then HALT
        prog_op[0] = 6'b001000; prog_op[1] = 6'b111111;
        exp_pc.push_back(4'd0); exp_pc.push_back(4'd1);
        exp_wb.push_back(4'b0011);
        prog_ready = 1'b1;
        step();
        check("addi_ir_load_c1", 32'(ir_load), 1);
        repeat (3) step();
        check("addi_reg_wr_c4", 32'(reg_wr), 1);
        check("addi_sel_operab", 32'(sel_operab), 1);
        step();
        check("addi_pc_after_wb", 32'(pc), 1);
        repeat (2) step();
        check("halt_busy", 32'(busy), 0);
        check("addi_wr_cnt", 32'(wr_cnt), 1);
        do_reset();

        // R-type AND/OR/XOR, ORI, ANDI then HALT
        prog_fn[0] = 6'b100100; prog_fn[1] = 6'b100101; prog_fn[2] = 6'b100110;
        prog_op[3] = 6'b001101; prog_op[4] = 6'b001100; prog_op[5] = 6'b111111;
        for (int i = 0; i < 6; i++) exp_pc.push_back(4'(i));
        exp_wb.push_back(4'b0100); exp_wb.push_back(4'b1000); exp_wb.push_back(4'b1100);
        exp_wb.push_back(4'b1011); exp_wb.push_back(4'b0111);
        prog_ready = 1'b1;
        run_until_idle(60, n);
        check("alu_cycles", 32'(n), 23);
        check("alu_wr_cnt", 32'(wr_cnt), 5);
        do_reset();

        // 16 NOPs incl. unknown opcode and bad funct: pc wraps, no writes
        prog_op[7] = 6'b010101; prog_fn[9] = 6'b000001;
        for (int i = 0; i < 16; i++) exp_pc.push_back(4'(i));
        exp_pc.push_back(4'd0);
        prog_ready = 1'b1;
        repeat (68) step();
        check("nop_wrap_pc", 32'(pc), 0);
        check("nop_wr_cnt", 32'(wr_cnt), 0);
        do_reset();

        // ADC with adc_done after 10 wait cycles
        prog_op[0] = 6'b110000; prog_op[1] = 6'b111111;
        exp_pc.push_back(4'd0); exp_pc.push_back(4'd1);
        prog_ready = 1'b1;
        repeat (3) step();
        check("adc_start_first", 32'(adc_start), 1);
        repeat (9) step();
        check("adc_wait_hold", 32'({busy, pc}), 32'h10);
        adc_done = 1'b1;
        step();
        check("adc_wb_no_wr", 32'(reg_wr), 0);
        adc_done = 1'b0;
        step();
        check("adc_next_fetch", 32'(ir_load), 1);
        check("adc_start_cnt", 32'(as_cnt), 1);
        repeat (2) step();
        do_reset();

        // HALT at pc 5, tick 20 cycles later
        prog_op[5] = 6'b111111;
        for (int i = 0; i < 6; i++) exp_pc.push_back(4'(i));
        prog_ready = 1'b1;
        run_until_idle(60, n);
        check("halt_cycles", 32'(n), 23);
        repeat (20) step();
        check("halt_pc_held", 32'({busy, pc}), 5);
        exp_pc.push_back(4'd0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("halt_tick_fetch", 32'(ir_load), 1);
        exp_pc.push_back(4'd1);
        repeat (4) step();
        do_reset();

        // tick in EXEC at pc 3, then tick coincident with WB
        prog_op[3] = 6'b001000;
        for (int i = 0; i < 4; i++) exp_pc.push_back(4'(i));
        exp_pc.push_back(4'd0);
        exp_wb.push_back(4'b0011);
        prog_ready = 1'b1;
        repeat (15) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("exec_tick_wb_wr", 32'(reg_wr), 1);
        step();
        check("exec_tick_pc", 32'(pc), 0);
        repeat (3) step();
        exp_pc.push_back(4'd0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("wb_tick_pc", 32'({ir_load, pc}), 32'h10);
        repeat (3) step();
        do_reset();

        // prog_ready falls during DECODE of pc 1
        prog_op[0] = 6'b001000; prog_op[1] = 6'b001000;
        exp_pc.push_back(4'd0); exp_pc.push_back(4'd1);
        exp_wb.push_back(4'b0011); exp_wb.push_back(4'b0011);
        prog_ready = 1'b1;
        repeat (6) step();
        prog_ready = 1'b0;
        repeat (2) step();
        check("drop_wb_wr", 32'(reg_wr), 1);
        repeat (5) step();
        check("drop_idle", 32'({busy, pc}), 0);
        exp_pc.push_back(4'd0);
        prog_ready = 1'b1;
        step();
        check("drop_restart", 32'(ir_load), 1);
        repeat (3) step();
        do_reset();

`ifdef SEQ_ADC_TIMEOUT_EN
        // ADC timeout after 255 wait cycles
        prog_op[0] = 6'b110000; prog_op[1] = 6'b111111;
        exp_pc.push_back(4'd0); exp_pc.push_back(4'd1);
        prog_ready = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!err && n < 400);
        check("timeout_cycles", 32'(n), 258);
        check("timeout_wb", 32'({reg_wr, pc}), 0);
        step();
        check("timeout_pc_adv", 32'(ir_load), 1);
        repeat (2) step();
        check("err_sticky", 32'({err, busy}), 32'h2);
`else
        // ADC wait without timeout never gives up
        prog_op[0] = 6'b110000;
        exp_pc.push_back(4'd0);
        prog_ready = 1'b1;
        repeat (300) step();
        check("adc_forever", 32'({err, busy, pc}), 32'h10);
        check("adc_forever_start", 32'(as_cnt), 1);
`endif
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
